// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath widths and the register-file
// clear-sweep state encoding.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear-sweep controller for the register file: walks every index once after
// reset or on clr_req, reporting busy while the sweep owns the write port.
module regfile_clear_fsm #(
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    import mips_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(2 ** ADDR_W - 1);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // NOTE: defaults at the top of the block keep every path assigned, so no
    // latch is inferred.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            READY: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                if (clr_req) begin
                    ptr_d = '0;
                end else if (ptr_q == LAST_IDX) begin
                    state_d = READY;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy     = (state_q == CLEAR);
        clr_we   = busy;
        clr_addr = ptr_q;
    end

endmodule

// File: rtl/regfile.sv
// 32x32 MIPS register file: two combinational read ports, one write-back port,
// a registered debug read port. Optional same-cycle bypass: REGFILE_BYPASS_EN.
module regfile #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    output logic              busy,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    import mips_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem_q [2 ** ADDR_W];
    logic [DATA_W-1:0] dbg_data_q;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wb_we;
    logic              rs_hit, rt_hit;

    regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // The sweep owns the write port while busy; write-back is simply dropped.
    assign wb_we = wr_en && !busy && (wr_addr != ZERO_IDX);

    // NOTE: the storage array has no reset term; the clear sweep zeroes it,
    // which keeps it mappable onto plain RAM/flop arrays.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wb_we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign rs_hit = wb_we && (wr_addr == rs_addr);
    assign rt_hit = wb_we && (wr_addr == rt_addr);
`else
    assign rs_hit = 1'b0;
    assign rt_hit = 1'b0;
`endif

    always_comb begin
        rs_data = rs_hit ? wr_data : mem_q[rs_addr];
        rt_data = rt_hit ? wr_data : mem_q[rt_addr];
        if (busy || rs_addr == ZERO_IDX) rs_data = '0;
        if (busy || rt_addr == ZERO_IDX) rt_data = '0;
    end

    // Debug reads come straight from storage, never from the bypass path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dbg_data_q <= '0;
        end else if (busy || dbg_addr == ZERO_IDX) begin
            dbg_data_q <= '0;
        end else begin
            dbg_data_q <= mem_q[dbg_addr];
        end
    end

    assign dbg_data = dbg_data_q;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: reset sweep, write/read vectors, bypass,
// debug port, clr_req sweep and reset mid-sweep.
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs_addr, rt_addr, wr_addr, dbg_addr;
    logic [31:0] rs_data, rt_data, wr_data, dbg_data;
    logic        wr_en, clr_req, busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
    } vec_t;
    vec_t vecs[9];

    regfile dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clr_req  (clr_req),
        .busy     (busy),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic sb_push(input string name, input logic [31:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [31:0] act);
        sb_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.name, act, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
    endtask

    // Counts cycles busy stays high from now (bounded), checking rs_data==0.
    task automatic count_busy(input string name, input logic drop_wr);
        int cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            rs_addr = 5'd3;
            if (drop_wr && cnt == 10) begin
                wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
            end else begin
                wr_en = 1'b0;
            end
            check({name, "_rs_zero"}, rs_data, 32'h0);
            tick();
        end
        wr_en = 1'b0;
        check({name, "_len"}, cnt, 32'd32);
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            check({name, "_rs"}, rs_data, 32'h0);
            check({name, "_rt"}, rt_data, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] byp_exp;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd2,  32'h0,        32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd0,  32'h1234,     5'd4,  5'd5,  32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        vecs[4] = '{1'b1, 5'd7,  32'h11,       5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
        vecs[5] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd7,  5'd7,  32'h11,       32'h11};
        vecs[6] = '{1'b0, 5'd5,  32'hFFFFFFFF, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[8] = '{1'b1, 5'd1,  32'h1,        5'd2,  5'd31, 32'h0,        32'hCAFEF00D};

        idle_inputs();
        rs_addr = '0; rt_addr = '0; dbg_addr = '0;
        rst_n = 1'b0;

        // Reset held for two edges, then a 32-cycle sweep.
        tick();
        tick();
        check("reset_busy", busy, 1'b1);
        check("reset_dbg", dbg_data, 32'h0);
        rst_n = 1'b1;
        count_busy("reset_sweep", 1'b0);
        check("reset_busy_low", busy, 1'b0);
        check_all_zero("reset_clear");

        // Table vectors: outputs checked before the write edge.
        for (int i = 0; i < 9; i++) begin
            wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
            rs_addr = vecs[i].rs_addr; rt_addr = vecs[i].rt_addr;
            sb_push($sformatf("vec%0d_rs", i), vecs[i].exp_rs);
            sb_push($sformatf("vec%0d_rt", i), vecs[i].exp_rt);
            #1;
            sb_pop_check(rs_data);
            sb_pop_check(rt_data);
            tick();
        end
        idle_inputs();

        // Same-cycle read of r7 while it is being overwritten.
`ifdef REGFILE_BYPASS_EN
        byp_exp = 32'hA5A5A5A5;
`else
        byp_exp = 32'h11;
`endif
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        rs_addr = 5'd7; rt_addr = 5'd7;
        #1;
        check("bypass_rs", rs_data, byp_exp);
        check("bypass_rt", rt_data, byp_exp);
        tick();
        idle_inputs();
        check("after_write_r7", rs_data, 32'hA5A5A5A5);

        // Debug port: one-cycle latency, no bypass.
        dbg_addr = 5'd31; sb_push("dbg_r31", 32'hCAFEF00D);
        tick(); sb_pop_check(dbg_data);
        dbg_addr = 5'd0;  sb_push("dbg_r0", 32'h0);
        tick(); sb_pop_check(dbg_data);
        dbg_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        sb_push("dbg_no_bypass", 32'h0);
        tick(); sb_pop_check(dbg_data);
        wr_en = 1'b0; sb_push("dbg_r9", 32'h99);
        tick(); sb_pop_check(dbg_data);
        rs_addr = 5'd31; rt_addr = 5'd31;
        #1;
        check("dual_r31_rs", rs_data, 32'hCAFEF00D);
        check("dual_r31_rt", rt_data, 32'hCAFEF00D);

        // Fill r1..r31 with their index; last write coincides with clr_req.
        for (int i = 1; i < 31; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i);
            tick();
        end
        wr_en = 1'b0;
        rs_addr = 5'd17; rt_addr = 5'd30;
        #1;
        check("fill_r17", rs_data, 32'd17);
        check("fill_r30", rt_data, 32'd30);
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'd31; clr_req = 1'b1;
        #1;
        check("clr_req_busy_before", busy, 1'b0);
        tick();
        idle_inputs();
        count_busy("clr_sweep", 1'b1);
        check_all_zero("clr_clear");

        // Reset at ptr==17 restarts a full sweep.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick();
            check("midsweep_busy", busy, 1'b1);
        end
        rst_n = 1'b0;
        tick();
        check("midsweep_reset_busy", busy, 1'b1);
        rst_n = 1'b1;
        count_busy("midsweep_restart", 1'b0);
        check("midsweep_busy_low", busy, 1'b0);

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
